sram_responder: RTL
===================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning word-address width (storage depth 2^ADDR_W words).
REQ-002 SHALL have parameter RD_WAIT, default 1, range 1..7, meaning cycles from first sampled read strobe to read data valid.
REQ-003 SHALL have port Clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Mem_CE  input  1  chip enable, active-low.
REQ-006 SHALL have port Mem_OE  input  1  read strobe, active-low.
REQ-007 SHALL have port Mem_WE  input  1  write strobe, active-low.
REQ-008 SHALL have ports Mem_UB, Mem_LB  input  1 each  upper/lower byte-lane enables, active-low.
REQ-009 SHALL have port ADDR  input  ADDR_W  word address.
REQ-010 SHALL have port Data_in  input  16  write data from initiator.
REQ-011 SHALL have port Err_Clr  input  1  synchronous clear of Proto_Err, active-high.
REQ-012 SHALL have port Data_out  output  16  registered read data.
REQ-013 SHALL have port Data_valid  output  1  Data_out holds valid read data this cycle.
REQ-014 SHALL have port Busy  output  1  access in progress (any state other than IDLE).
REQ-015 SHALL have port Proto_Err  output  1  sticky protocol-violation flag.

Function
REQ-016 SHALL implement FSM states IDLE, RD_WAIT, RD_DATA, WR_WAIT, WR_DONE.
REQ-017 SHALL treat a cycle as "selected" only when Mem_CE=0; while Mem_CE=1, all strobes are ignored and the FSM returns to IDLE on the next edge without side effects.
REQ-018 IDLE: selected with OE=0, WE=1 -> latch ADDR, UB, LB, load wait counter with RD_WAIT-1, go RD_WAIT (or straight to RD_DATA when RD_WAIT=1, with Data_out loaded on that edge).
REQ-019 RD_WAIT: counter decrements each cycle OE stays 0; on reaching 0, load Data_out from the latched address and go RD_DATA.
REQ-020 RD_DATA: Data_valid=1; remain while OE=0; OE=1 -> IDLE, Data_valid=0 next cycle.
REQ-021 Read data SHALL be valid in the cycle that is RD_WAIT cycles after the first cycle in which OE is sampled low; with the default, a two-cycle OE-low read has data valid in its second cycle.
REQ-022 Read lanes: Data_out[15:8] SHALL be 0 if latched UB=1; Data_out[7:0] SHALL be 0 if latched LB=1.
REQ-023 OE returning to 1 during RD_WAIT -> abort to IDLE, Data_valid stays 0, Proto_Err set.
REQ-024 IDLE: selected with WE=0, OE=1 -> latch ADDR, Data_in, UB, LB; go WR_WAIT.
REQ-025 WR_WAIT: WE still 0 -> commit enabled byte lanes to storage on this edge, go WR_DONE; WE=1 -> abort to IDLE, no storage change, Proto_Err set.
REQ-026 WR_DONE: hold until WE=1, then IDLE; no further writes while held.
REQ-027 OE=0 and WE=0 together, in any state -> no storage write, Data_valid=0, go IDLE, Proto_Err set.
REQ-028 Address or data changes after the latch cycle SHALL be ignored for the current access.
REQ-029 Err_Clr=1 SHALL clear Proto_Err on the next edge unless a new violation occurs that same cycle (set wins).
REQ-030 Back-to-back accesses SHALL be accepted, i.e. a new strobe sampled in the IDLE cycle immediately following a return to IDLE.

Reset
REQ-031 Reset=0 SHALL immediately force state IDLE, Data_out=16'h0000, Data_valid=0, Busy=0, Proto_Err=0, counter=0.
REQ-032 Reset SHALL NOT clear storage contents; an in-flight write not yet committed SHALL be discarded.
REQ-033 Reset deassertion SHALL be effective from the next rising edge.

Verification
REQ-034 Write 16'hBEEF to addr 8'h10 (CE=0, WE=0 for 2 cycles, UB=LB=0), then read with OE=0 for 2 cycles -> Data_valid=1 and Data_out=16'hBEEF in read cycle 2.
REQ-035 Write 16'h1234 to 8'h20 with UB=1 over prior 16'hFFFF; read -> 16'hFF34; read with LB=1 -> 16'hFF00.
REQ-036 WE=0 for only 1 cycle at addr 8'h30 holding 16'hAAAA -> storage unchanged (readback 16'hAAAA), Proto_Err=1; Err_Clr pulse -> Proto_Err=0.
REQ-037 RD_WAIT=3, OE=0 for 4 cycles -> Data_valid=0 for cycles 1-3, 1 in cycle 4; OE=0 for 2 cycles only -> Data_valid never 1, Proto_Err=1.
REQ-038 OE=0 and WE=0 together -> no write, Proto_Err=1; Reset=0 asserted mid-WR_WAIT -> all outputs reset at once, target word unchanged.

Source files
------------

// File: rtl/sram_responder.sv
// ---------------------------------------------------------------------------
// sram_responder
//   Target-side model of an asynchronous-style SRAM bus, sampled on Clk.
//   An initiator drives active-low chip enable, output enable and write
//   enable strobes. Reads return data RD_WAIT cycles after the first sampled
//   OE-low cycle. Writes commit on the second WE-low cycle. Malformed strobe
//   sequences set the sticky Proto_Err flag.
//
// Parameters
//   ADDR_W   word-address width (storage depth 2**ADDR_W x 16 bits)
//   RD_WAIT  read latency in cycles, 1..7
//
// Ports
//   Clk         sole clock, rising edge
//   Reset       asynchronous, active-low reset
//   Mem_CE      chip enable, active-low
//   Mem_OE      read strobe, active-low
//   Mem_WE      write strobe, active-low
//   Mem_UB      upper byte-lane enable, active-low
//   Mem_LB      lower byte-lane enable, active-low
//   ADDR        word address
//   Data_in     write data
//   Err_Clr     synchronous clear of Proto_Err, active-high
//   Data_out    registered read data
//   Data_valid  Data_out carries valid read data this cycle
//   Busy        access in progress
//   Proto_Err   sticky protocol-violation flag
// ---------------------------------------------------------------------------
module sram_responder #(
  parameter int ADDR_W  = 8,
  parameter int RD_WAIT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Mem_CE,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic              Mem_UB,
  input  logic              Mem_LB,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [15:0]       Data_in,
  input  logic              Err_Clr,
  output logic [15:0]       Data_out,
  output logic              Data_valid,
  output logic              Busy,
  output logic              Proto_Err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_DATA,
    ST_WR_WAIT,
    ST_WR_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              ub_q, lb_q;

  logic              start_rd, start_wr, load_dout, commit, err_set;

  logic [15:0]       mem [2**ADDR_W];

  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ub, rd_lb;
  logic [15:0]       rd_word;

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    start_rd  = 1'b0;
    start_wr  = 1'b0;
    load_dout = 1'b0;
    commit    = 1'b0;
    err_set   = 1'b0;

    if (Mem_CE) begin
      // Deselected: strobes are don't-care, drop any access silently.
      state_d = ST_IDLE;
    end else if (!Mem_OE && !Mem_WE) begin
      // Both strobes low is illegal in every state.
      state_d = ST_IDLE;
      err_set = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!Mem_OE) begin
            start_rd = 1'b1;
            if (RD_WAIT == 1) begin
              load_dout = 1'b1;
              state_d   = ST_RD_DATA;
            end else begin
              cnt_d   = 3'(RD_WAIT - 1);
              state_d = ST_RD_WAIT;
            end
          end else if (!Mem_WE) begin
            start_wr = 1'b1;
            state_d  = ST_WR_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (Mem_OE) begin
            state_d = ST_IDLE;
            err_set = 1'b1;
          end else if (cnt_q == 3'd1) begin
            // Counter reaches zero on this edge: data becomes valid next cycle.
            load_dout = 1'b1;
            state_d   = ST_RD_DATA;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        ST_RD_DATA: begin
          if (Mem_OE) state_d = ST_IDLE;
        end
        ST_WR_WAIT: begin
          if (Mem_WE) begin
            state_d = ST_IDLE;
            err_set = 1'b1;
          end else begin
            commit  = 1'b1;
            state_d = ST_WR_DONE;
          end
        end
        ST_WR_DONE: begin
          if (Mem_WE) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // With a single-cycle latency the read is served straight from the bus
  // inputs on the latch edge; otherwise from the latched copies.
  assign rd_addr = start_rd ? ADDR   : addr_q;
  assign rd_ub   = start_rd ? Mem_UB : ub_q;
  assign rd_lb   = start_rd ? Mem_LB : lb_q;
  assign rd_word = mem[rd_addr];

  // ---------------------------------------------------------------------------
  // Control state and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ub_q      <= 1'b1;
      lb_q      <= 1'b1;
      Data_out  <= 16'h0000;
      Proto_Err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;

      if (start_rd || start_wr) begin
        addr_q <= ADDR;
        ub_q   <= Mem_UB;
        lb_q   <= Mem_LB;
      end
      if (start_wr) wdata_q <= Data_in;

      if (load_dout) begin
        Data_out <= {rd_ub ? 8'h00 : rd_word[15:8],
                     rd_lb ? 8'h00 : rd_word[7:0]};
      end

      // A violation in the same cycle as a clear request keeps the flag set.
      if (err_set)      Proto_Err <= 1'b1;
      else if (Err_Clr) Proto_Err <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; contents survive Reset. An uncommitted write
  // is dropped because Reset forces the FSM out of ST_WR_WAIT.
  always_ff @(posedge Clk) begin
    if (commit) begin
      if (!ub_q) mem[addr_q][15:8] <= wdata_q[15:8];
      if (!lb_q) mem[addr_q][7:0]  <= wdata_q[7:0];
    end
  end

  assign Data_valid = (state_q == ST_RD_DATA);
  assign Busy       = (state_q != ST_IDLE);

endmodule
